lbp_hist: RTL and testbench
===========================

# lbp_hist

Downstream consumer of the LBP core's output stream. Snoops the `lbp_valid`/`lbp_addr`/`lbp_data` write bus in parallel with the LBP result memory and builds a 256-bin histogram of LBP codes for one 128x128 frame. After `finish`, it streams the 256 bin counts out in bin order. It never back-pressures the LBP core.

## Interface

Parameters:

- `IMG_W`, 128: image width in pixels; must be a power of two.
- `IMG_H`, 128: image height in pixels.
- `EXCLUDE_BORDER`, 1: when 1, samples whose address lies on the frame border are not counted.
- `CNT_W`, 15: width of each bin counter.

Ports:

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `lbp_valid`  in  1  LBP result valid; sampled on the rising edge.
- `lbp_addr`  in  14  pixel address, raster order: row = addr[13:7], col = addr[6:0].
- `lbp_data`  in  8  LBP code; this is the bin index.
- `finish`  in  1  LBP core frame-complete level.
- `hist_valid`  out  1  `hist_bin`/`hist_count` are valid this cycle.
- `hist_bin`  out  8  bin index being output.
- `hist_count`  out  CNT_W  count for `hist_bin`.
- `hist_done`  out  1  readout complete; held high until reset.
- `pix_count`  out  CNT_W  total number of samples counted.

## Operation

**States**

- `ACCUM`: entered on reset.
- `ACCUM` → `DRAIN` on the edge where `finish` is sampled high.
- `DRAIN` → `READ` after exactly 1 cycle.
- `READ` → `DONE` after 256 read issues.
- `DONE` is terminal until reset.

**Clearing**

- Each bin has a valid bit, held in a 256-bit vector that reset clears in one cycle.
- A bin whose valid bit is 0 reads as 0. No clear pass is needed, so counting can start in the cycle right after reset.

**Accumulate**

- A sample counts when all of these hold:
  - `lbp_valid` is 1;
  - state is `ACCUM`;
  - it is not excluded. With `EXCLUDE_BORDER`=1, a sample is excluded if row ∈ {0, IMG_H-1} or col ∈ {0, IMG_W-1}.
- Counting uses a 2-stage read-modify-write:
  - Stage A (cycle t): RAM read address = `lbp_data`; the bin is registered.
  - Stage B (cycle t+1): new = (valid bit ? rdata : 0) + 1, saturating at 2^CNT_W-1. The RAM write and the valid-bit set happen at the end of t+1.
- RAM read-during-write to the same address returns the old data.
- Forwarding: if the stage-B bin equals the bin written in the previous cycle, use the previously written value instead of rdata. This makes back-to-back and alternating same-bin samples count exactly.
- `pix_count` increments once per counted sample and saturates.

**Edge cases**

- `lbp_valid` in `DRAIN`, `READ` or `DONE` is ignored.
- When `finish` and `lbp_valid` are high on the same edge, the sample is counted.

**Readout**

- In `READ`, the read address steps 0..255, one per cycle.
- `hist_valid`, `hist_bin` and `hist_count` are registered and aligned to the 1-cycle RAM latency.
- A bin with valid bit 0 outputs count 0.
- There is no backpressure: the consumer must accept every cycle.

**Reset mid-operation**

- Reset returns to `ACCUM` from any state.
- It clears all valid bits and `pix_count`.
- It drops `hist_valid` and `hist_done` in the next cycle and discards any in-flight stage-B write.

## Timing

- Reset values: `hist_valid`=0, `hist_bin`=0, `hist_count`=0, `hist_done`=0, `pix_count`=0.
- A sample at edge t is reflected in the RAM and in `pix_count` after edge t+1.
- `finish` sampled at the edge ending cycle t gives:
  - t+1: `DRAIN`;
  - t+2: first `READ` issue;
  - t+3..t+258: `hist_valid`=1, with bins 0..255 consecutive;
  - t+259 onward: `hist_done`=1.
- Throughput: one sample per cycle sustained, with no gaps required.

## Structure

- Package `lbp_pkg` holds:
  - constants `IMG_W`, `IMG_H`, `ADDR_W`=14, `BIN_W`=8;
  - the state enum (`ACCUM`, `DRAIN`, `READ`, `DONE`).
- Sub-module `lbp_hist_ram`:
  - 256 x CNT_W, one synchronous read port and one write port, 1-cycle read latency, read-old-data on collision.
  - It contains no reset; validity comes from the valid-bit vector in `lbp_hist`.

## Test plan

1. **Uniform frame.** `EXCLUDE_BORDER`=0, 16384 samples with data 0x00, then `finish`.
   - Required: bin 0 = 16384, all other bins 0, `pix_count`=16384.
2. **Forwarding.** Data 0x5A on three consecutive cycles, a 1-cycle gap, then 0x5A again; separately the pattern 0x11, 0x22, 0x11, 0x22 back-to-back.
   - Required: 0x5A = 4, 0x11 = 2, 0x22 = 2.
3. **Border exclusion.** `EXCLUDE_BORDER`=1, full raster with data = addr[7:0].
   - Required: `pix_count`=15876 and the sum of all bins = 15876.
4. **Readout timing.** `finish` sampled at edge t.
   - Required: first `hist_valid` in t+3, exactly 256 contiguous valid cycles with `hist_bin` 0..255, `hist_done` rising at t+259.
5. **Reset mid-frame.** Reset after 5000 samples of 0xFF, then a fresh 100 samples of 0x01 and `finish`.
   - Required: 0xFF = 0, 0x01 = 100.
6. **Post-finish samples ignored.** Drive `lbp_valid` with data 0x33 during `DRAIN` and `READ`.
   - Required: bin 0x33 unchanged and `pix_count` unchanged.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared constants and state encoding for the LBP histogram block.
package lbp_pkg;
    localparam int IMG_W    = 128;
    localparam int IMG_H    = 128;
    localparam int ADDR_W   = 14;
    localparam int BIN_W    = 8;
    localparam int NUM_BINS = 256;

    typedef enum logic [1:0] {ACCUM, DRAIN, READ, DONE} state_e;
endpackage

// File: rtl/lbp_hist_ram.sv
// 256-entry bin storage: one sync read port, one write port, read-old-data on collision.
module lbp_hist_ram
    import lbp_pkg::*;
#(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             we,
    input  logic [BIN_W-1:0] waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [BIN_W-1:0] raddr,
    output logic [CNT_W-1:0] rdata
);
    logic [CNT_W-1:0] mem [NUM_BINS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/lbp_hist.sv
// Snoops the LBP write bus, accumulates a 256-bin code histogram, then streams the bins out.
module lbp_hist #(
    parameter int IMG_W          = lbp_pkg::IMG_W,
    parameter int IMG_H          = lbp_pkg::IMG_H,
    parameter int EXCLUDE_BORDER = 1,
    parameter int CNT_W          = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       lbp_valid,
    input  logic [lbp_pkg::ADDR_W-1:0] lbp_addr,
    input  logic [lbp_pkg::BIN_W-1:0]  lbp_data,
    input  logic                       finish,
    output logic                       hist_valid,
    output logic [lbp_pkg::BIN_W-1:0]  hist_bin,
    output logic [CNT_W-1:0]           hist_count,
    output logic                       hist_done,
    output logic [CNT_W-1:0]           pix_count
);
    import lbp_pkg::*;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = ADDR_W - COL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                state_q, state_d;
    logic                  b_vld_q, b_vld_d;
    logic [BIN_W-1:0]      b_bin_q, b_bin_d;
    logic                  wr_vld_q, wr_vld_d;
    logic [BIN_W-1:0]      wr_bin_q, wr_bin_d;
    logic [CNT_W-1:0]      wr_val_q, wr_val_d;
    logic [NUM_BINS-1:0]   vbits_q, vbits_d;
    logic [CNT_W-1:0]      pix_q, pix_d;
    logic [BIN_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  hist_valid_q, hist_valid_d;
    logic [BIN_W-1:0]      hist_bin_q, hist_bin_d;
    logic                  rd_vbit_q, rd_vbit_d;
    logic                  done_q, done_d;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             on_border, accept, ram_we;
    logic [BIN_W-1:0] ram_raddr;
    logic [CNT_W-1:0] ram_rdata, base, new_val;

    assign col       = lbp_addr[COL_W-1:0];
    assign row       = lbp_addr[ADDR_W-1:COL_W];
    assign on_border = (row == '0) || (row == ROW_W'(IMG_H - 1)) ||
                       (col == '0) || (col == COL_W'(IMG_W - 1));
    assign accept    = lbp_valid && (state_q == ACCUM) && !((EXCLUDE_BORDER != 0) && on_border);

    // Stage B: a write from the previous cycle is not yet visible in rdata, so forward it.
    assign base    = (wr_vld_q && (wr_bin_q == b_bin_q)) ? wr_val_q :
                     (vbits_q[b_bin_q] ? ram_rdata : '0);
    assign new_val = (base == CNT_MAX) ? base : base + CNT_W'(1);
    assign ram_we  = b_vld_q && !reset;

    always_comb begin
        state_d      = state_q;
        b_vld_d      = accept;
        b_bin_d      = lbp_data;
        wr_vld_d     = b_vld_q;
        wr_bin_d     = b_bin_q;
        wr_val_d     = new_val;
        vbits_d      = vbits_q;
        pix_d        = pix_q;
        rd_ptr_d     = rd_ptr_q;
        hist_valid_d = (state_q == READ);
        hist_bin_d   = (state_q == READ) ? rd_ptr_q : hist_bin_q;
        rd_vbit_d    = (state_q == READ) && vbits_q[rd_ptr_q];
        done_d       = (state_q == DONE);
        ram_raddr    = (state_q == ACCUM) ? lbp_data : rd_ptr_q;
        if (b_vld_q) begin
            vbits_d[b_bin_q] = 1'b1;
            if (pix_q != CNT_MAX) pix_d = pix_q + CNT_W'(1);
        end
        case (state_q)
            ACCUM: if (finish) state_d = DRAIN;
            DRAIN: begin
                state_d  = READ;
                rd_ptr_d = '0;
            end
            READ: begin
                rd_ptr_d = rd_ptr_q + BIN_W'(1);
                if (rd_ptr_q == '1) state_d = DONE;
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            b_vld_q      <= 1'b0;
            b_bin_q      <= '0;
            wr_vld_q     <= 1'b0;
            wr_bin_q     <= '0;
            wr_val_q     <= '0;
            vbits_q      <= '0;
            pix_q        <= '0;
            rd_ptr_q     <= '0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= '0;
            rd_vbit_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            b_vld_q      <= b_vld_d;
            b_bin_q      <= b_bin_d;
            wr_vld_q     <= wr_vld_d;
            wr_bin_q     <= wr_bin_d;
            wr_val_q     <= wr_val_d;
            vbits_q      <= vbits_d;
            pix_q        <= pix_d;
            rd_ptr_q     <= rd_ptr_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            rd_vbit_q    <= rd_vbit_d;
            done_q       <= done_d;
        end
    end

    lbp_hist_ram #(.CNT_W(CNT_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (b_bin_q),
        .wdata (new_val),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign hist_valid = hist_valid_q;
    assign hist_bin   = hist_bin_q;
    assign hist_count = rd_vbit_q ? ram_rdata : '0;
    assign hist_done  = done_q;
    assign pix_count  = pix_q;
endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench: two instances (border counted / excluded) share one input bus.
module tb_lbp_hist;
    logic        clk = 1'b0;
    logic        reset, lbp_valid, finish;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        hv0, hd0, hv1, hd1;
    logic [7:0]  hb0, hb1;
    logic [14:0] hc0, pc0, hc1, pc1;

    int errors = 0;
    int checks = 0;
    int m0[256];
    int m1[256];
    int p0, p1, sum0, sum1;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    lbp_hist #(.EXCLUDE_BORDER(0)) dut0 (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hv0), .hist_bin(hb0),
        .hist_count(hc0), .hist_done(hd0), .pix_count(pc0));
    lbp_hist #(.EXCLUDE_BORDER(1)) dut1 (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hv1), .hist_bin(hb1),
        .hist_count(hc1), .hist_done(hd1), .pix_count(pc1));

    function automatic int sat_inc(input int v);
        return (v >= 32767) ? 32767 : v + 1;
    endfunction

    function automatic bit interior(input logic [13:0] a);
        return (a[13:7] != 7'd0) && (a[13:7] != 7'd127) && (a[6:0] != 7'd0) && (a[6:0] != 7'd127);
    endfunction

    task automatic drive_sample(input logic [13:0] a, input logic [7:0] d);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        @(posedge clk); #1;
        lbp_valid = 1'b0;
        m0[d] = sat_inc(m0[d]);
        p0    = sat_inc(p0);
        if (interior(a)) begin
            m1[d] = sat_inc(m1[d]);
            p1    = sat_inc(p1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; lbp_valid = 1'b0; finish = 1'b0; lbp_addr = '0; lbp_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int b = 0; b < 256; b++) begin m0[b] = 0; m1[b] = 0; end
        p0 = 0; p1 = 0;
        checks += 2;
        if ({hv0, hb0, hc0, hd0, pc0} !== 40'd0) begin
            errors++; $display("FAIL reset_dut0: got %h required 0", {hv0, hb0, hc0, hd0, pc0});
        end
        if ({hv1, hb1, hc1, hd1, pc1} !== 40'd0) begin
            errors++; $display("FAIL reset_dut1: got %h required 0", {hv1, hb1, hc1, hd1, pc1});
        end
    endtask

    // finish is sampled at edge t; loop index k is cycle t+k
    task automatic run_readout(input bit junk);
        int e0, e1;
        for (int b = 0; b < 256; b++) begin q0.push_back(m0[b]); q1.push_back(m1[b]); end
        sum0 = 0; sum1 = 0;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        for (int k = 1; k <= 262; k++) begin
            bit ev, ed;
            ev = (k >= 3) && (k <= 258);
            ed = (k >= 259);
            checks += 4;
            if (hv0 !== ev) begin errors++; $display("FAIL valid0 cyc %0d: got %b required %b", k, hv0, ev); end
            if (hv1 !== ev) begin errors++; $display("FAIL valid1 cyc %0d: got %b required %b", k, hv1, ev); end
            if (hd0 !== ed) begin errors++; $display("FAIL done0 cyc %0d: got %b required %b", k, hd0, ed); end
            if (hd1 !== ed) begin errors++; $display("FAIL done1 cyc %0d: got %b required %b", k, hd1, ed); end
            if (ev && hv0 === 1'b1 && hv1 === 1'b1) begin
                e0 = (q0.size() > 0) ? q0.pop_front() : -1;
                e1 = (q1.size() > 0) ? q1.pop_front() : -1;
                sum0 += int'(hc0);
                sum1 += int'(hc1);
                checks += 4;
                if (hb0 !== 8'(k - 3)) begin errors++; $display("FAIL bin0: got %0d required %0d", hb0, k - 3); end
                if (hb1 !== 8'(k - 3)) begin errors++; $display("FAIL bin1: got %0d required %0d", hb1, k - 3); end
                if (int'(hc0) != e0) begin errors++; $display("FAIL count0 bin %0d: got %0d required %0d", k - 3, hc0, e0); end
                if (int'(hc1) != e1) begin errors++; $display("FAIL count1 bin %0d: got %0d required %0d", k - 3, hc1, e1); end
            end
            if (junk && k <= 100) begin
                lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'h33;
            end else begin
                lbp_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        lbp_valid = 1'b0;
        checks += 3;
        if (q0.size() + q1.size() != 0) begin
            errors++; $display("FAIL drained: got %0d leftover required 0", q0.size() + q1.size());
            q0.delete(); q1.delete();
        end
        if (int'(pc0) != p0) begin errors++; $display("FAIL pix0: got %0d required %0d", pc0, p0); end
        if (int'(pc1) != p1) begin errors++; $display("FAIL pix1: got %0d required %0d", pc1, p1); end
    endtask

    task automatic test_uniform();
        test_reset();
        for (int i = 0; i < 16384; i++) drive_sample(14'(i), 8'h00);
        run_readout(1'b0);
        checks += 2;
        if (pc0 !== 15'd16384) begin errors++; $display("FAIL uniform_pix: got %0d required 16384", pc0); end
        if (sum0 != 16384) begin errors++; $display("FAIL uniform_sum: got %0d required 16384", sum0); end
    endtask

    task automatic test_forwarding();
        test_reset();
        drive_sample(14'd129, 8'h5A);
        drive_sample(14'd130, 8'h5A);
        drive_sample(14'd131, 8'h5A);
        @(posedge clk); #1;
        drive_sample(14'd132, 8'h5A);
        drive_sample(14'd133, 8'h11);
        drive_sample(14'd134, 8'h22);
        drive_sample(14'd135, 8'h11);
        drive_sample(14'd136, 8'h22);
        run_readout(1'b0);
        checks += 1;
        if (sum1 != 8) begin errors++; $display("FAIL forward_sum: got %0d required 8", sum1); end
    endtask

    task automatic test_border();
        test_reset();
        for (int i = 0; i < 16384; i++) drive_sample(14'(i), 8'(i));
        run_readout(1'b0);
        checks += 2;
        if (pc1 !== 15'd15876) begin errors++; $display("FAIL border_pix: got %0d required 15876", pc1); end
        if (sum1 != 15876) begin errors++; $display("FAIL border_sum: got %0d required 15876", sum1); end
    endtask

    task automatic test_reset_midframe();
        test_reset();
        for (int i = 0; i < 5000; i++) drive_sample(14'(i), 8'hFF);
        test_reset();
        for (int i = 0; i < 100; i++) drive_sample(14'(200 + i), 8'h01);
        run_readout(1'b0);
    endtask

    task automatic test_post_finish();
        test_reset();
        for (int i = 0; i < 3; i++) drive_sample(14'(300 + i), 8'h33);
        drive_sample(14'd400, 8'h44);
        run_readout(1'b1);
        checks += 1;
        if (pc1 !== 15'd4) begin errors++; $display("FAIL post_pix: got %0d required 4", pc1); end
    endtask

    task automatic test_back_to_back_reset_after_done();
        test_reset();
        drive_sample(14'd129, 8'h07);
        test_reset();
        drive_sample(14'd129, 8'h07);
        run_readout(1'b0);
    endtask

    initial begin
        reset = 1'b1; lbp_valid = 1'b0; finish = 1'b0; lbp_addr = '0; lbp_data = '0;
        @(posedge clk); #1;
        test_reset();
        test_uniform();
        test_forwarding();
        test_border();
        test_reset_midframe();
        test_post_finish();
        test_back_to_back_reset_after_done();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
